string_printer: RTL
===================

# string_printer

Downstream consumer of the terminal control state machine's `state_string` selector. The state machine selects a message code, and this block streams that fixed ASCII message one byte at a time to the UART transmitter over a valid/ready handshake. When the last byte has been accepted, it returns a one-cycle `printer_done` pulse, which is the signal the state machine waits for before re-enabling input.

## Interface
Parameters:
- `MAX_LEN`, default 16: maximum characters per message; sets the index counter width to `$clog2(MAX_LEN+1)`.

Ports:
- `clk`  in  1  single system clock; all logic is on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `string_sel`  in  3  message code from the state machine. Codes:
  - NONE=000, INTRO=001, BENCH=010, ALU=011, CPU=100, INVALID=101, REPORT=110.
  - 111 is reserved and treated as NONE.
- `tx_data`  out  8  current ASCII byte; registered.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  the UART transmitter accepts `tx_data` this cycle.
- `printer_done`  out  1  one-cycle pulse after the final byte of a message is accepted.
- `busy`  out  1  high in every state except IDLE.

## Operation
Message contents (CR=0x0D, LF=0x0A):
- INTRO: "EC551 Lab2" CR LF, 12 bytes.
- BENCH: "BENCH" CR LF, 7 bytes.
- ALU: "ALU" CR LF, 5 bytes.
- CPU: "CPU" CR LF, 5 bytes.
- INVALID: "INVALID" CR LF, 9 bytes.
- REPORT: "DONE" CR LF, 6 bytes.

State machine (IDLE, SEND, WAIT_CLR):
- **IDLE:**
  - If `string_sel` is a valid non-NONE code: latch the code, set index to 0, load `tx_data` with byte 0, set `tx_valid`=1, go to SEND.
  - Otherwise stay in IDLE.
- **SEND:**
  - On a beat (`tx_valid && tx_ready`): index increments.
  - If the accepted byte was the last one: `tx_valid`<=0, `printer_done`<=1, go to WAIT_CLR.
  - Otherwise: `tx_data` <= next byte and `tx_valid` stays 1.
  - With no beat, `tx_data` and `tx_valid` hold.
- **WAIT_CLR:**
  - `printer_done` is deasserted after its single cycle.
  - Stay until `string_sel` reads NONE or 111, then go to IDLE.
  - This re-arm rule prevents a re-print while the state machine still drives the old code during the cycle it samples `printer_done`.

Further rules:
- `string_sel` is sampled only in IDLE. Changes during SEND or WAIT_CLR are ignored; the latched code governs the whole message.
- The index never exceeds the message length, so there is no wrap-around.
- `tx_valid` never drops without a beat while in SEND.

## Timing
- Reset values: state=IDLE, `tx_data`=0x00, `tx_valid`=0, `printer_done`=0, `busy`=0, index=0, latched code=NONE.
- Reset asserted mid-message clears all state immediately; no `printer_done` is issued and the partial message is abandoned.
- Start latency: `string_sel` valid at rising edge N, then `tx_valid`=1 with byte 0 from edge N (visible in cycle N+1).
- Throughput: one byte per cycle while `tx_ready`=1.
- `printer_done` is high exactly one cycle, starting the cycle after the edge that accepted the last byte. `tx_valid` is low in that same cycle.
- The earliest next message starts one cycle after `string_sel` returns to NONE while in WAIT_CLR.

## Structure
- Shared package/include `printer_defs` holds:
  - the STRING_* codes (shared with the state machine);
  - the ASCII constants CR and LF;
  - the state encodings IDLE, SEND, WAIT_CLR.
- One sub-module, `string_rom`:
  - inputs: the code (3) and index.
  - outputs: the byte (8) and a `last` flag.
  - purely combinational.
- The top level holds the FSM, the index counter and the output registers.

## Test plan
- **ALU, no stall:** `tx_ready`=1, pulse `string_sel`=011 then hold it.
  - Expect five consecutive beats: 0x41, 0x4C, 0x55, 0x0D, 0x0A.
  - `printer_done` high for one cycle right after the 0x0A beat; no second print while `string_sel` stays 011.
- **Backpressure:** INVALID, with `tx_ready` low for 3 cycles on byte 2 ('V', 0x56).
  - `tx_data` holds 0x56 and `tx_valid` stays 1 throughout the stall.
  - Total of 9 beats, then exactly one done pulse.
- **Re-arm:** REPORT completes, then `string_sel`→NONE for 1 cycle, then →001.
  - Expect the 12-byte INTRO to start, first byte 0x45.
- **Mid-message change:** BENCH starts, and `string_sel` switches to 100 after the second beat.
  - Output is still exactly "BENCH" CR LF.
- **Reset mid-message:** assert `rst` during byte 3 of INTRO.
  - `tx_valid`=0, `busy`=0 and `printer_done`=0 take effect without waiting for an edge.
  - After release with `string_sel`=NONE: the block stays idle.
- **Reserved code:** `string_sel`=111 for 10 cycles.
  - `tx_valid` stays 0, `busy` stays 0, no done pulse.

Source files
------------

// File: rtl/printer_defs.sv
// Shared definitions for the terminal message printer.
//   - STRING_* message codes (also driven by the terminal control state machine)
//   - ASCII CR / LF constants
//   - printer FSM state encoding
//   - MSG_MAX: length of the longest message, which sets the ROM row width
package printer_defs;

  localparam logic [2:0] STRING_NONE    = 3'b000;
  localparam logic [2:0] STRING_INTRO   = 3'b001;
  localparam logic [2:0] STRING_BENCH   = 3'b010;
  localparam logic [2:0] STRING_ALU     = 3'b011;
  localparam logic [2:0] STRING_CPU     = 3'b100;
  localparam logic [2:0] STRING_INVALID = 3'b101;
  localparam logic [2:0] STRING_REPORT  = 3'b110;
  localparam logic [2:0] STRING_RSVD    = 3'b111;

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;

  localparam int MSG_MAX = 12;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_CLR = 2'd2
  } state_t;

  // The reserved code behaves exactly like NONE.
  function automatic logic is_msg_code(input logic [2:0] code);
    return (code != STRING_NONE) && (code != STRING_RSVD);
  endfunction

endpackage

// File: rtl/string_rom.sv
// Combinational message ROM.
//   code : message code (STRING_*)
//   idx  : byte position within the message
//   data : ASCII byte at idx (0x00 when idx is past the end or code is NONE)
//   last : idx addresses the final byte of the message
// Each message is stored left-aligned in a MSG_MAX-byte row, byte 0 in the
// most significant position.
module string_rom
  import printer_defs::*;
#(
  parameter int IDX_W = 5
) (
  input  logic [2:0]       code,
  input  logic [IDX_W-1:0] idx,
  output logic [7:0]       data,
  output logic             last
);

  localparam int ROW_W = 8 * MSG_MAX;

  localparam logic [ROW_W-1:0] MSG_INTRO   = {"EC551 Lab2", CR, LF};
  localparam logic [ROW_W-1:0] MSG_BENCH   = {"BENCH", CR, LF, 40'h0};
  localparam logic [ROW_W-1:0] MSG_ALU     = {"ALU", CR, LF, 56'h0};
  localparam logic [ROW_W-1:0] MSG_CPU     = {"CPU", CR, LF, 56'h0};
  localparam logic [ROW_W-1:0] MSG_INVALID = {"INVALID", CR, LF, 24'h0};
  localparam logic [ROW_W-1:0] MSG_REPORT  = {"DONE", CR, LF, 48'h0};

  logic [ROW_W-1:0] row;
  int               len;
  int               pos;

  always_comb begin
    row = '0;
    len = 0;
    case (code)
      STRING_INTRO:   begin row = MSG_INTRO;   len = 12; end
      STRING_BENCH:   begin row = MSG_BENCH;   len = 7;  end
      STRING_ALU:     begin row = MSG_ALU;     len = 5;  end
      STRING_CPU:     begin row = MSG_CPU;     len = 5;  end
      STRING_INVALID: begin row = MSG_INVALID; len = 9;  end
      STRING_REPORT:  begin row = MSG_REPORT;  len = 6;  end
      default:        begin row = '0;          len = 0;  end
    endcase

    pos  = int'(idx);
    data = 8'h00;
    last = 1'b0;
    if (pos < len) begin
      data = row[ROW_W-1-8*pos -: 8];
      last = (pos == len - 1);
    end
  end

endmodule

// File: rtl/string_printer.sv
// Streams a fixed ASCII message, selected by string_sel, one byte per
// valid/ready beat to the UART transmitter, then pulses printer_done.
//   clk          : system clock, rising edge
//   rst          : asynchronous active-high reset
//   string_sel   : message code, sampled only while idle
//   tx_data      : current ASCII byte (registered)
//   tx_valid     : tx_data is valid
//   tx_ready     : transmitter accepts tx_data this cycle
//   printer_done : one-cycle pulse after the final byte is accepted
//   busy         : high whenever the printer is not idle
module string_printer
  import printer_defs::*;
#(
  parameter int MAX_LEN = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] string_sel,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       printer_done,
  output logic       busy
);

  localparam int IDX_W = $clog2(MAX_LEN + 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_next;
  logic [2:0]       code_q;
  logic             last_q;

  logic [2:0]       rom_code;
  logic [IDX_W-1:0] rom_idx;
  logic [7:0]       rom_data;
  logic             rom_last;

  assign idx_next = idx + IDX_W'(1);

  // A single ROM port serves both lookups: byte 0 of the incoming code while
  // idle, otherwise the byte following the one on tx_data. The last flag is
  // captured with each byte so the SEND state knows when the beat ends the
  // message without a second lookup.
  assign rom_code = (state == IDLE) ? string_sel : code_q;
  assign rom_idx  = (state == IDLE) ? '0 : idx_next;

  string_rom #(
    .IDX_W (IDX_W)
  ) u_rom (
    .code (rom_code),
    .idx  (rom_idx),
    .data (rom_data),
    .last (rom_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      code_q       <= STRING_NONE;
      last_q       <= 1'b0;
      tx_data      <= 8'h00;
      tx_valid     <= 1'b0;
      printer_done <= 1'b0;
      busy         <= 1'b0;
    end else begin
      printer_done <= 1'b0;
      case (state)
        IDLE: begin
          if (is_msg_code(string_sel)) begin
            code_q   <= string_sel;
            idx      <= '0;
            tx_data  <= rom_data;
            last_q   <= rom_last;
            tx_valid <= 1'b1;
            busy     <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          if (tx_valid && tx_ready) begin
            idx <= idx_next;
            if (last_q) begin
              tx_valid     <= 1'b0;
              printer_done <= 1'b1;
              state        <= WAIT_CLR;
            end else begin
              tx_data <= rom_data;
              last_q  <= rom_last;
            end
          end
        end
        WAIT_CLR: begin
          // Re-arm only once the selector has been withdrawn, so a code still
          // held while printer_done is being sampled does not print twice.
          if (!is_msg_code(string_sel)) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
